muldiv_sequencer: RTL and testbench

//  Controller for the multiply/divide resource in the multicycle CPU datapath. Accepts one-cycle

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_sequencer_if.sv | 39 +++
 rtl/muldiv_watchdog.sv | 27 ++
 rtl/muldiv_sequencer.sv | 111 +++++++++++
 tb/tb_muldiv_sequencer.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the multiply/divide sequencer: FSM state encoding,
// error cause codes and the default datapath width.
package muldiv_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START_M = 3'd1,
        WAIT_M  = 3'd2,
        START_D = 3'd3,
        WAIT_D  = 3'd4,
        DONE    = 3'd5,
        ERR     = 3'd6
    } muldiv_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_DIV0    = 2'd1,
        ERR_TIMEOUT = 2'd2
    } muldiv_err_t;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Bundle between the control FSM / mul-div units (master) and the
// sequencer (slave): requests, unit handshakes, results and status.
interface muldiv_sequencer_if #(
    parameter int DATA_W = muldiv_pkg::DATA_W
);
    logic              MultReq;
    logic              DivReq;
    logic [DATA_W-1:0] OpB;
    logic              MultEnd;
    logic              DivEnd;
    logic [DATA_W-1:0] MultHighIn;
    logic [DATA_W-1:0] MultLowIn;
    logic [DATA_W-1:0] DivHighIn;
    logic [DATA_W-1:0] DivLowIn;
    logic              StartMult;
    logic              StartDiv;
    logic              Busy;
    logic              Done;
    logic              DivZero;
    logic              Timeout;
    logic              WrHigh;
    logic              WrLow;
    logic [DATA_W-1:0] HighReg;
    logic [DATA_W-1:0] LowReg;

    modport master (
        output MultReq, DivReq, OpB, MultEnd, DivEnd,
               MultHighIn, MultLowIn, DivHighIn, DivLowIn,
        input  StartMult, StartDiv, Busy, Done, DivZero, Timeout,
               WrHigh, WrLow, HighReg, LowReg
    );

    modport slave (
        input  MultReq, DivReq, OpB, MultEnd, DivEnd,
               MultHighIn, MultLowIn, DivHighIn, DivLowIn,
        output StartMult, StartDiv, Busy, Done, DivZero, Timeout,
               WrHigh, WrLow, HighReg, LowReg
    );
endinterface

// File: rtl/muldiv_watchdog.sv
// Saturating cycle counter for the WAIT states; expired flags the last
// permitted wait cycle so the FSM can leave for ERR on the same edge.
module muldiv_watchdog #(
    parameter int MAX_WAIT = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_WAIT - 1);

    logic [CNT_W-1:0] count;

    assign expired = (count == LAST);

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/muldiv_sequencer.sv
// Sequences one MULT/DIV operation: start pulse, watchdog-guarded wait for
// the unit's End, then commit the unit's results into the HI/LO registers.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int DATA_W   = muldiv_pkg::DATA_W,
    parameter int MAX_WAIT = 64
) (
    input  logic               clock,
    input  logic               reset,
    muldiv_sequencer_if.slave  bus
);
    muldiv_state_t     state_q, state_d;
    muldiv_err_t       cause_q, cause_d;
    logic              wd_clr, wd_en, wd_expired;
    logic              wr;
    logic [DATA_W-1:0] high_q, low_q;
    logic [DATA_W-1:0] high_sel, low_sel;

    muldiv_watchdog #(.MAX_WAIT(MAX_WAIT)) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cause_q <= ERR_NONE;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        wd_clr  = 1'b0;
        wd_en   = 1'b0;
        wr      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.MultReq) begin
                    state_d = START_M;
                end else if (bus.DivReq) begin
                    if (bus.OpB == '0) begin
                        state_d = ERR;
                        cause_d = ERR_DIV0;
                    end else begin
                        state_d = START_D;
                    end
                end
            end
            START_M: begin
                state_d = WAIT_M;
                wd_clr  = 1'b1;
            end
            START_D: begin
                state_d = WAIT_D;
                wd_clr  = 1'b1;
            end
            WAIT_M, WAIT_D: begin
                if ((state_q == WAIT_M) ? bus.MultEnd : bus.DivEnd) begin
                    wr      = 1'b1;
                    state_d = DONE;
                end else if (wd_expired) begin
                    state_d = ERR;
                    cause_d = ERR_TIMEOUT;
                end else begin
                    wd_en = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            ERR: begin
                state_d = IDLE;
                cause_d = ERR_NONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Only WAIT_D selects the divider; wr is never set outside the WAIT states.
    assign high_sel = (state_q == WAIT_D) ? bus.DivHighIn : bus.MultHighIn;
    assign low_sel  = (state_q == WAIT_D) ? bus.DivLowIn  : bus.MultLowIn;

    // NOTE: HI/LO are architectural state and must be cleared by reset, unlike a RAM.
    always_ff @(posedge clock) begin
        if (reset) begin
            high_q <= '0;
            low_q  <= '0;
        end else if (wr) begin
            high_q <= high_sel;
            low_q  <= low_sel;
        end
    end

    assign bus.StartMult = (state_q == START_M);
    assign bus.StartDiv  = (state_q == START_D);
    assign bus.Busy      = (state_q != IDLE);
    assign bus.Done      = (state_q == DONE);
    assign bus.DivZero   = (state_q == ERR) && (cause_q == ERR_DIV0);
    assign bus.Timeout   = (state_q == ERR) && (cause_q == ERR_TIMEOUT);
    assign bus.WrHigh    = wr;
    assign bus.WrLow     = wr;
    assign bus.HighReg   = high_q;
    assign bus.LowReg    = low_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with MAX_WAIT=8; expected values are
// hand-derived per cycle, where cycle 0 is the cycle the request is driven.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int MAX_WAIT = 8;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    muldiv_sequencer_if #(.DATA_W(DATA_W)) bus ();

    muldiv_sequencer #(.DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        bus.MultReq = 1'b0;
        bus.DivReq  = 1'b0;
        bus.MultEnd = 1'b0;
        bus.DivEnd  = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        clear_inputs();
        bus.OpB        = '0;
        bus.MultHighIn = '0;
        bus.MultLowIn  = '0;
        bus.DivHighIn  = '0;
        bus.DivLowIn   = '0;
        repeat (3) next_cycle();

        // Reset state
        check("rst_busy",    32'(bus.Busy),      32'd0);
        check("rst_done",    32'(bus.Done),      32'd0);
        check("rst_smult",   32'(bus.StartMult), 32'd0);
        check("rst_sdiv",    32'(bus.StartDiv),  32'd0);
        check("rst_divzero", 32'(bus.DivZero),   32'd0);
        check("rst_timeout", 32'(bus.Timeout),   32'd0);
        check("rst_hi",      bus.HighReg,        32'd0);
        check("rst_lo",      bus.LowReg,         32'd0);
        reset = 1'b0;

        // 1: MULT, End at cycle 5 -> Done at 6
        for (int c = 0; c <= 8; c++) begin
            clear_inputs();
            bus.MultReq    = (c == 0);
            bus.MultEnd    = (c == 5);
            bus.MultHighIn = 32'h0000_0001;
            bus.MultLowIn  = 32'hFFFF_0000;
            @(negedge clock);
            check($sformatf("t1_smult_c%0d", c), 32'(bus.StartMult), 32'(c == 1));
            check($sformatf("t1_done_c%0d", c),  32'(bus.Done),      32'(c == 6));
            check($sformatf("t1_busy_c%0d", c),  32'(bus.Busy),      32'(c >= 1 && c <= 6));
            check($sformatf("t1_wr_c%0d", c),    32'(bus.WrHigh && bus.WrLow), 32'(c == 5));
            next_cycle();
        end
        check("t1_hi", bus.HighReg, 32'h0000_0001);
        check("t1_lo", bus.LowReg,  32'hFFFF_0000);

        // 2: DIV by 7, End at cycle 3 -> Done at 4
        for (int c = 0; c <= 6; c++) begin
            clear_inputs();
            bus.DivReq    = (c == 0);
            bus.OpB       = 32'd7;
            bus.DivEnd    = (c == 3);
            bus.DivHighIn = 32'd2;
            bus.DivLowIn  = 32'd5;
            @(negedge clock);
            check($sformatf("t2_sdiv_c%0d", c),  32'(bus.StartDiv),  32'(c == 1));
            check($sformatf("t2_smult_c%0d", c), 32'(bus.StartMult), 32'd0);
            check($sformatf("t2_done_c%0d", c),  32'(bus.Done),      32'(c == 4));
            next_cycle();
        end
        check("t2_hi", bus.HighReg, 32'd2);
        check("t2_lo", bus.LowReg,  32'd5);

        // 3: DIV by zero -> DivZero at cycle 1, HI/LO untouched
        for (int c = 0; c <= 4; c++) begin
            clear_inputs();
            bus.DivReq    = (c == 0);
            bus.OpB       = 32'd0;
            bus.DivHighIn = 32'hDEAD_BEEF;
            bus.DivLowIn  = 32'hCAFE_F00D;
            @(negedge clock);
            check($sformatf("t3_divzero_c%0d", c), 32'(bus.DivZero),  32'(c == 1));
            check($sformatf("t3_sdiv_c%0d", c),    32'(bus.StartDiv), 32'd0);
            check($sformatf("t3_done_c%0d", c),    32'(bus.Done),     32'd0);
            check($sformatf("t3_busy_c%0d", c),    32'(bus.Busy),     32'(c == 1));
            check($sformatf("t3_timeout_c%0d", c), 32'(bus.Timeout),  32'd0);
            next_cycle();
        end
        check("t3_hi", bus.HighReg, 32'd2);
        check("t3_lo", bus.LowReg,  32'd5);

        // 4: MULT never ends -> WAIT_M lasts 8 cycles (2..9), Timeout at 10
        for (int c = 0; c <= 13; c++) begin
            clear_inputs();
            bus.MultReq    = (c == 0);
            bus.MultHighIn = 32'h1111_1111;
            bus.MultLowIn  = 32'h2222_2222;
            @(negedge clock);
            check($sformatf("t4_timeout_c%0d", c), 32'(bus.Timeout), 32'(c == 10));
            check($sformatf("t4_busy_c%0d", c),    32'(bus.Busy),    32'(c >= 1 && c <= 10));
            check($sformatf("t4_done_c%0d", c),    32'(bus.Done),    32'd0);
            check($sformatf("t4_divzero_c%0d", c), 32'(bus.DivZero), 32'd0);
            next_cycle();
        end
        check("t4_hi", bus.HighReg, 32'd2);
        check("t4_lo", bus.LowReg,  32'd5);

        // 5: simultaneous MULT+DIV, then DIV requests while busy are dropped
        for (int c = 0; c <= 8; c++) begin
            clear_inputs();
            bus.MultReq    = (c == 0);
            bus.DivReq     = (c == 0) || (c == 2) || (c == 3);
            bus.OpB        = 32'd3;
            bus.MultEnd    = (c == 4);
            bus.MultHighIn = 32'h0000_000A;
            bus.MultLowIn  = 32'h0000_000B;
            bus.DivHighIn  = 32'h0000_0099;
            bus.DivLowIn   = 32'h0000_0088;
            @(negedge clock);
            check($sformatf("t5_smult_c%0d", c), 32'(bus.StartMult), 32'(c == 1));
            check($sformatf("t5_sdiv_c%0d", c),  32'(bus.StartDiv),  32'd0);
            check($sformatf("t5_done_c%0d", c),  32'(bus.Done),      32'(c == 5));
            check($sformatf("t5_busy_c%0d", c),  32'(bus.Busy),      32'(c >= 1 && c <= 5));
            next_cycle();
        end
        check("t5_hi", bus.HighReg, 32'h0000_000A);
        check("t5_lo", bus.LowReg,  32'h0000_000B);

        // 6: reset during WAIT_D, late DivEnd afterwards is ignored
        for (int c = 0; c <= 7; c++) begin
            clear_inputs();
            reset         = (c == 3);
            bus.DivReq    = (c == 0);
            bus.OpB       = 32'd9;
            bus.DivEnd    = (c == 4) || (c == 5);
            bus.DivHighIn = 32'h0000_0077;
            bus.DivLowIn  = 32'h0000_0066;
            @(negedge clock);
            if (c <= 3) begin
                check($sformatf("t6_busy_c%0d", c), 32'(bus.Busy),     32'(c >= 1));
                check($sformatf("t6_sdiv_c%0d", c), 32'(bus.StartDiv), 32'(c == 1));
            end else begin
                check($sformatf("t6_busy_c%0d", c),  32'(bus.Busy),     32'd0);
                check($sformatf("t6_done_c%0d", c),  32'(bus.Done),     32'd0);
                check($sformatf("t6_sdiv_c%0d", c),  32'(bus.StartDiv), 32'd0);
                check($sformatf("t6_wr_c%0d", c),    32'(bus.WrHigh || bus.WrLow), 32'd0);
                check($sformatf("t6_pulse_c%0d", c), 32'(bus.DivZero || bus.Timeout || bus.StartMult), 32'd0);
                check($sformatf("t6_hi_c%0d", c),    bus.HighReg, 32'd0);
                check($sformatf("t6_lo_c%0d", c),    bus.LowReg,  32'd0);
            end
            next_cycle();
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
